// File: rtl/sorted_merge_pkg.sv
// ---------------------------------------------------------------------------
// sorted_merge_pkg
//   Definitions shared by the sort network and its merge stages:
//   - merge_state_t : two-state control for a pairwise merge (IDLE, MERGE)
//   - clog2()       : index-width helper, usable in constant expressions
//   - DEF_NUM_VALS / DEF_SIZE : default vector length and element width
//                               common to the sorter and the merge levels
// ---------------------------------------------------------------------------
package sorted_merge_pkg;

  localparam int unsigned DEF_NUM_VALS = 9;
  localparam int unsigned DEF_SIZE     = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } merge_state_t;

  // Smallest r with 2**r >= v (clog2(1) = 0).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/merge_head_sel.sv
// ---------------------------------------------------------------------------
// merge_head_sel
//   Combinational head selector for a two-way descending merge. Picks the
//   larger of the two stream heads; ties and an exhausted B stream go to A.
//   Comparison is unsigned.
//
// Parameters
//   SIZE      element width in bits
// Ports
//   i_a_head  current head of stream A
//   i_b_head  current head of stream B
//   i_a_ok    stream A still has elements
//   i_b_ok    stream B still has elements
//   o_pick_b  0 = A selected, 1 = B selected
//   o_data    selected head
// ---------------------------------------------------------------------------
module merge_head_sel #(
  parameter int unsigned SIZE = 16
) (
  input  logic [SIZE-1:0] i_a_head,
  input  logic [SIZE-1:0] i_b_head,
  input  logic            i_a_ok,
  input  logic            i_b_ok,
  output logic            o_pick_b,
  output logic [SIZE-1:0] o_data
);

  logic w_pick_a;

  always_comb begin
    w_pick_a = i_a_ok && (!i_b_ok || (i_a_head >= i_b_head));
    o_pick_b = !w_pick_a;
    o_data   = w_pick_a ? i_a_head : i_b_head;
  end

endmodule

// File: rtl/sorted_pair_merge.sv
// ---------------------------------------------------------------------------
// sorted_pair_merge
//   Captures two descending-sorted vectors in one handshake and streams their
//   merged union out largest-first, one element per cycle, under valid/ready
//   back-pressure. One IDLE cycle separates consecutive pairs, so a pair
//   occupies 2*NUM_VALS+1 cycles at full output rate.
//
// Optional build macro
//   SORTED_PAIR_MERGE_CHECK_EN : when defined, each captured pair is checked
//   for descending order and any violation sets err_unsorted, which stays set
//   until reset. When undefined, err_unsorted is tied low and no check logic
//   exists. The port list is the same either way.
//
// Parameters
//   NUM_VALS      elements per input vector
//   SIZE          element width in bits (unsigned)
// Ports
//   clk           clock, rising edge
//   rst_n         synchronous active-low reset
//   in_valid      in_a/in_b hold a pair to merge
//   in_ready      block can capture a pair (low while in reset)
//   in_a, in_b    sorted vectors, slice 0 is the largest element
//   out_valid     out_data holds a merged element
//   out_ready     consumer accepts out_data
//   out_data      current merged element
//   out_src       0 = element from A, 1 = from B
//   out_last      final (2*NUM_VALS-th) element of the pair
//   err_unsorted  sticky input-order error
// ---------------------------------------------------------------------------
module sorted_pair_merge
  import sorted_merge_pkg::*;
#(
  parameter int unsigned NUM_VALS = DEF_NUM_VALS,
  parameter int unsigned SIZE     = DEF_SIZE
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_VALS*SIZE-1:0] in_a,
  input  logic [NUM_VALS*SIZE-1:0] in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SIZE-1:0]          out_data,
  output logic                     out_src,
  output logic                     out_last,
  output logic                     err_unsorted
);

  localparam int unsigned   IW       = clog2(NUM_VALS + 1);
  localparam int unsigned   SW       = IW + 1;
  localparam logic [IW-1:0] PTR_MAX  = IW'(NUM_VALS);
  localparam logic [SW-1:0] LAST_SUM = SW'(2 * NUM_VALS - 1);

  merge_state_t    r_state;
  merge_state_t    w_state_nxt;
  logic            r_run;
  logic [SIZE-1:0] r_a [NUM_VALS];
  logic [SIZE-1:0] r_b [NUM_VALS];
  logic [IW-1:0]   r_ia;
  logic [IW-1:0]   r_ib;

  logic            w_a_ok;
  logic            w_b_ok;
  logic [SIZE-1:0] w_head_a;
  logic [SIZE-1:0] w_head_b;
  logic            w_pick_b;
  logic [SIZE-1:0] w_sel_data;
  logic            w_last;
  logic            w_capture;
  logic            w_beat;

  // -------------------------------------------------------------------------
  // Head lookup. The pointer reaches NUM_VALS when a stream is exhausted, so
  // a compare-and-select loop is used instead of a direct index to keep the
  // out-of-range case well defined (head reads as zero, and *_ok masks it).
  // -------------------------------------------------------------------------
  always_comb begin
    w_head_a = '0;
    w_head_b = '0;
    for (int unsigned k = 0; k < NUM_VALS; k++) begin
      if (r_ia == IW'(k)) w_head_a = r_a[k];
      if (r_ib == IW'(k)) w_head_b = r_b[k];
    end
  end

  always_comb begin
    w_a_ok = (r_ia < PTR_MAX);
    w_b_ok = (r_ib < PTR_MAX);
    w_last = (({1'b0, r_ia} + {1'b0, r_ib}) == LAST_SUM);
  end

  merge_head_sel #(
    .SIZE (SIZE)
  ) u_head_sel (
    .i_a_head (w_head_a),
    .i_b_head (w_head_b),
    .i_a_ok   (w_a_ok),
    .i_b_ok   (w_b_ok),
    .o_pick_b (w_pick_b),
    .o_data   (w_sel_data)
  );

  // -------------------------------------------------------------------------
  // Outputs: functions of registered state only. r_run keeps in_ready low
  // while reset is asserted even though the state register already sits in
  // IDLE; it rises on the first edge after release.
  // -------------------------------------------------------------------------
  always_comb begin
    in_ready  = r_run && (r_state == IDLE);
    out_valid = (r_state == MERGE);
    out_data  = out_valid ? w_sel_data : '0;
    out_src   = out_valid && w_pick_b;
    out_last  = out_valid && w_last;
  end

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_beat      = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid && in_ready) begin
          w_capture   = 1'b1;
          w_state_nxt = MERGE;
        end
      end
      MERGE: begin
        if (out_ready) begin
          w_beat = 1'b1;
          if (w_last) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: captured vectors and stream pointers. Pointers saturate at
  // NUM_VALS; the selector never picks an exhausted stream, so the guard only
  // matters for robustness.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NUM_VALS; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
      end
      r_ia <= '0;
      r_ib <= '0;
    end else if (w_capture) begin
      for (int unsigned k = 0; k < NUM_VALS; k++) begin
        r_a[k] <= in_a[k*SIZE +: SIZE];
        r_b[k] <= in_b[k*SIZE +: SIZE];
      end
      r_ia <= '0;
      r_ib <= '0;
    end else if (w_beat) begin
      if (w_pick_b) begin
        if (r_ib < PTR_MAX) r_ib <= r_ib + IW'(1);
      end else begin
        if (r_ia < PTR_MAX) r_ia <= r_ia + IW'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Optional input-order check
  // -------------------------------------------------------------------------
`ifdef SORTED_PAIR_MERGE_CHECK_EN
  logic r_err;
  logic w_viol;

  always_comb begin
    w_viol = 1'b0;
    for (int unsigned k = 0; k + 1 < NUM_VALS; k++) begin
      if (in_a[k*SIZE +: SIZE] < in_a[(k+1)*SIZE +: SIZE]) w_viol = 1'b1;
      if (in_b[k*SIZE +: SIZE] < in_b[(k+1)*SIZE +: SIZE]) w_viol = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_capture && w_viol) begin
      r_err <= 1'b1;
    end
  end

  assign err_unsorted = r_err;
`else
  assign err_unsorted = 1'b0;
`endif

endmodule

// File: doc/sorted_pair_merge.md
# sorted_pair_merge

Downstream merge stage for the 9-entry sort network. Accepts two already-sorted (descending) vectors, such as two consecutive registered outputs of the sorter, in one handshake. Streams their merged union out one element per cycle, largest first, under valid/ready back-pressure. Together with the sorter it forms the second level of the merge-sort pipeline.

## Interface
Parameters:
- NUM_VALS, 9: elements per input vector.
- SIZE, 16: element width in bits, unsigned.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset; one clock, synchronous, active-low.
- in_valid  input  1  in_a/in_b hold a pair to merge.
- in_ready  output  1  block can capture a pair.
- in_a  input  NUM_VALS*SIZE  sorted vector A; slice 0 (bits SIZE-1:0) is the largest element.
- in_b  input  NUM_VALS*SIZE  sorted vector B, same layout.
- out_valid  output  1  out_data holds a merged element.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  SIZE  current merged element.
- out_src  output  1  0 = element from A, 1 = from B.
- out_last  output  1  element is the 2*NUM_VALS-th of the pair.
- err_unsorted  output  1  sticky input-order error; see Configuration.

## Operation
- States: IDLE, MERGE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture in_a and in_b into internal arrays, clear ia and ib, go to MERGE.
- MERGE:
  - in_ready=0; out_valid=1.
  - Head selection:
    - a_ok = ia<NUM_VALS; b_ok = ib<NUM_VALS.
    - Pick A when a_ok and (!b_ok or A[ia] >= B[ib]); otherwise pick B.
    - Ties go to A.
    - Comparison is unsigned, SIZE bits.
  - out_data is the picked head. out_src is the pick.
  - out_last = (ia+ib == 2*NUM_VALS-1).
  - On out_valid&&out_ready:
    - Increment the picked pointer.
    - If out_last, go to IDLE.
  - With out_ready=0: out_data, out_src and out_last hold stable.
- Pointer width: clog2(NUM_VALS+1). A pointer saturates at NUM_VALS and never wraps.
- in_valid while in MERGE is ignored; the upstream holds the pair until in_ready.
- Reset mid-MERGE:
  - Abandon the pair: state IDLE, pointers 0, arrays 0.
  - No out_last is emitted for the abandoned pair.
- Reset values:
  - in_ready=0 while rst_n=0, 1 from the first cycle after release.
  - out_valid=0, out_data=0, out_src=0, out_last=0, err_unsorted=0.

## Timing
- Capture at edge T. out_valid is high in cycle T+1 with the first (largest) element.
- Full throughput: 2*NUM_VALS output cycles per pair.
- One IDLE bubble cycle between pairs: the next pair is captured at the earliest on the edge after the out_last handshake. Sustained rate is 2*NUM_VALS+1 cycles per pair.
- in_ready depends only on state, never combinationally on in_valid. out_valid does not depend on out_ready.
- Outputs are combinational from registered state only; there is no input-to-output combinational path.

## Configuration
- Macro: SORTED_PAIR_MERGE_CHECK_EN.
- Defined:
  - On each capture, check in_a and in_b for slice[k] >= slice[k+1] for all k.
  - Any violation sets err_unsorted on the following edge.
  - err_unsorted stays set until rst_n=0.
  - The merge still proceeds unchanged; output order is then unspecified.
- Undefined:
  - err_unsorted is tied to 0.
  - No check logic is built.
- The port list is identical in both builds.

## Structure
- Package sorted_merge_pkg:
  - State enum (IDLE, MERGE).
  - Index-width function clog2.
  - Default NUM_VALS/SIZE constants shared with the sorter.
- Sub-module merge_head_sel:
  - Combinational.
  - Inputs: both heads and both *_ok flags.
  - Outputs: pick and selected data.
  - Reused by later merge levels.

## Test plan
- A={9,6,5,3,1,1,0,0,0}, B={8,7,4,2,2,0,0,0,0}, out_ready=1 -> 18 consecutive beats: 9,8,7,6,5,4,3,2,2,1,1,0×7. out_last only on beat 18. First beat is the cycle after capture.
- A=B={5,5,5,5,5,5,5,5,5} -> all 9 A beats (out_src=0) precede the 9 B beats (out_src=1).
- Random out_ready toggling (50%) with the first pair -> same 18-value sequence. Data stable during every stall. in_ready stays 0 until after out_last.
- Two back-to-back pairs with in_valid held high -> second capture exactly one cycle after the first pair's out_last handshake. No element lost or duplicated.
- rst_n low at beat 7 of a pair -> next cycle: out_valid=0, in_ready=0 while rst_n=0. After release: in_ready=1, a new pair merges correctly.
- With SORTED_PAIR_MERGE_CHECK_EN, A={1,2,0,0,0,0,0,0,0} -> err_unsorted=1 the cycle after capture, held through later clean pairs until reset. Without the macro, err_unsorted=0 throughout.
